lsm_pipelined: RTL

//  Load/store stage with pipelined Wishbone: up to MAX_OUTSTANDING memory requests in flight,

---
 rtl/ecap5_dproc_pkg.sv | 31 +++
 rtl/lsm_pending_queue.sv | 51 +++++
 rtl/lsm_pipelined.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared types for the load/store stage: size encodings, pending-entry layout and request states.
package ecap5_dproc_pkg;

  localparam logic [3:0] SEL_BYTE = 4'h1;
  localparam logic [3:0] SEL_HALF = 4'h3;
  localparam logic [3:0] SEL_WORD = 4'hF;

  typedef struct packed {
    logic [1:0] off;
    logic [3:0] sel;
    logic       uns;
    logic       we;
    logic       reg_write;
    logic [4:0] reg_addr;
  } lsm_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } lsm_req_state_t;

  // Any size code other than byte or half behaves as a full word.
  function automatic logic [3:0] norm_sel(input logic [3:0] sel);
    case (sel)
      SEL_BYTE: return SEL_BYTE;
      SEL_HALF: return SEL_HALF;
      default:  return SEL_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsm_pending_queue.sv
// In-order FIFO of issued-but-unanswered memory requests; head is the oldest outstanding beat.
module lsm_pending_queue
  import ecap5_dproc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  lsm_entry_t                   entry_i,
  input  logic                         pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output lsm_entry_t                   head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  lsm_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (pop_i)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= entry_i;
  end

  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/lsm_pipelined.sv
// Load/store stage with a pipelined Wishbone master, in-order retire and lane steering.
//  state | meaning
//  IDLE  | no strobe pending; bus idle or only waiting on acks
//  REQ   | strobe asserted with latched beat, waiting for !wb_stall_i
module lsm_pipelined
  import ecap5_dproc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TRAP_MISALIGNED = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic [31:0] alu_result_i,
  input  logic        enable_i,
  input  logic        write_i,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  sel_i,
  input  logic        unsigned_load_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,
  input  logic        wb_err_i,
  output logic        output_valid_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o,
  output logic        misaligned_o,
  output logic        bus_error_o
);

  localparam int CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam bit TRAP_EN = (TRAP_MISALIGNED != 0);

  lsm_req_state_t r_state;
  logic           r_stb;
  logic [31:0]    r_adr;
  logic [31:0]    r_dat;
  logic           r_we;
  logic [3:0]     r_sel;
  logic           r_output_valid;
  logic           r_reg_write;
  logic [4:0]     r_reg_addr;
  logic [31:0]    r_reg_data;
  logic           r_misaligned;
  logic           r_bus_error;

  logic [1:0]     w_off_raw;
  logic [1:0]     w_off;
  logic [3:0]     w_sel;
  logic           w_misal;
  logic           w_trap;
  logic           w_mem;
  logic           w_ready;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic [CW-1:0]  w_count;
  lsm_entry_t     w_entry;
  lsm_entry_t     w_head;
  logic [31:0]    w_shifted;
  logic [31:0]    w_load_data;

  assign w_off_raw = alu_result_i[1:0];
  assign w_sel     = norm_sel(sel_i);
  assign w_misal   = ((w_sel == SEL_HALF) && (w_off_raw == 2'd3)) ||
                     ((w_sel == SEL_WORD) && (w_off_raw != 2'd0));
  assign w_off     = w_misal ? 2'd0 : w_off_raw;
  assign w_trap    = enable_i & w_misal & TRAP_EN;
  assign w_mem     = enable_i & ~w_trap;

  // Non-memory and trapped results must wait for the bus to drain so retirement stays in order.
  assign w_ready  = w_mem ? ((w_count < CW'(MAX_OUTSTANDING)) & (~r_stb | ~wb_stall_i))
                          : ((w_count == '0) & ~r_stb);
  assign w_accept = input_valid_i & w_ready;
  assign w_push   = w_accept & w_mem;
  assign w_pop    = (wb_ack_i | wb_err_i) & (w_count != '0);

  assign w_entry = '{off: w_off, sel: w_sel, uns: unsigned_load_i, we: write_i,
                     reg_write: reg_write_i, reg_addr: reg_addr_i};

  lsm_pending_queue #(.DEPTH(MAX_OUTSTANDING)) u_pending (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .entry_i (w_entry),
    .pop_i   (w_pop),
    .count_o (w_count),
    .head_o  (w_head)
  );

  assign w_shifted = wb_dat_i >> {w_head.off, 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (w_head.sel)
      SEL_BYTE: w_load_data = {{24{~w_head.uns & w_shifted[7]}}, w_shifted[7:0]};
      SEL_HALF: w_load_data = {{16{~w_head.uns & w_shifted[15]}}, w_shifted[15:0]};
      default:  w_load_data = w_shifted;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_stb   <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_push) begin
            r_state <= REQ;
            r_stb   <= 1'b1;
            r_adr   <= {alu_result_i[31:2], 2'b00};
            r_dat   <= write_data_i << {w_off, 3'b000};
            r_we    <= write_i;
            r_sel   <= w_sel << w_off;
          end
        end
        REQ: begin
          if (w_push) begin
            r_adr <= {alu_result_i[31:2], 2'b00};
            r_dat <= write_data_i << {w_off, 3'b000};
            r_we  <= write_i;
            r_sel <= w_sel << w_off;
          end else if (!wb_stall_i) begin
            r_state <= IDLE;
            r_stb   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_stb   <= 1'b0;
        end
      endcase
    end
  end

  // Error outranks ack; queue pop and a non-memory/trapped accept never coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_output_valid <= 1'b0;
      r_reg_write    <= 1'b0;
      r_reg_addr     <= '0;
      r_reg_data     <= '0;
      r_misaligned   <= 1'b0;
      r_bus_error    <= 1'b0;
    end else begin
      r_output_valid <= 1'b0;
      r_misaligned   <= 1'b0;
      r_bus_error    <= 1'b0;
      if (w_pop) begin
        r_output_valid <= 1'b1;
        r_reg_addr     <= w_head.reg_addr;
        if (wb_err_i) begin
          r_bus_error <= 1'b1;
          r_reg_write <= 1'b0;
          r_reg_data  <= '0;
        end else begin
          r_reg_write <= w_head.reg_write & ~w_head.we;
          r_reg_data  <= w_head.we ? 32'h0 : w_load_data;
        end
      end else if (w_accept && w_trap) begin
        r_output_valid <= 1'b1;
        r_misaligned   <= 1'b1;
        r_reg_write    <= 1'b0;
        r_reg_addr     <= reg_addr_i;
      end else if (w_accept && !enable_i) begin
        r_output_valid <= 1'b1;
        r_reg_write    <= reg_write_i;
        r_reg_addr     <= reg_addr_i;
        r_reg_data     <= alu_result_i;
      end
    end
  end

  assign input_ready_o  = w_ready;
  assign wb_adr_o       = r_adr;
  assign wb_dat_o       = r_dat;
  assign wb_we_o        = r_we;
  assign wb_sel_o       = r_sel;
  assign wb_stb_o       = r_stb;
  assign wb_cyc_o       = r_stb | (w_count != '0);
  assign output_valid_o = r_output_valid;
  assign reg_write_o    = r_reg_write;
  assign reg_addr_o     = r_reg_addr;
  assign reg_data_o     = r_reg_data;
  assign misaligned_o   = r_misaligned;
  assign bus_error_o    = r_bus_error;

endmodule
